serial_nibble_loader: RTL and testbench

Serial-to-parallel front end for the lab's enabled D-register bank. It receives a framed serial word (WIDTH data bits LSB-first, plus an optional parity bit) and presents the assembled word on data_out. On a good frame it issues a one-cycle load pulse, intended to drive the enable of the downstream WIDTH-bit register. Bad-parity frames are dropped and flagged with err.

---
 rtl/serial_nibble_loader_pkg.sv | 11 +
 rtl/serial_nibble_loader_bit_counter.sv | 24 ++
 rtl/serial_nibble_loader.sv | 72 +++++++
 tb/tb_serial_nibble_loader.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/serial_nibble_loader_pkg.sv
// serial_nibble_loader_pkg: shared FSM state encoding and default frame width.
// Ports: none.
package serial_nibble_loader_pkg;
   localparam int DEFAULT_WIDTH = 4;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2,
      DONE   = 2'd3
   } state_t;
endpackage

// File: rtl/serial_nibble_loader_bit_counter.sv
// serial_nibble_loader_bit_counter: data-bit counter with clear, increment and terminal count.
// Ports: clk, reset (async, active-high), clr (clear, wins over inc), inc (count one bit),
//        tc (counter currently at WIDTH-1).
module serial_nibble_loader_bit_counter
   import serial_nibble_loader_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic tc
);
   localparam int CW = $clog2(WIDTH);
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb begin
      cnt_d = clr ? '0 : inc ? cnt_q + CW'(1) : cnt_q;
      tc    = cnt_q == CW'(WIDTH - 1);
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
endmodule

// File: rtl/serial_nibble_loader.sv
// serial_nibble_loader: LSB-first serial frame receiver with optional parity, feeding a register enable.
// Ports: clk, reset (async, active-high), start (frame request, IDLE only), abort (sync cancel),
//        sval (sdata valid), sdata (serial data/parity), busy (SHIFT/PARITY/DONE),
//        data_out (last accepted word), load (one-cycle good-frame pulse), err (one-cycle parity-error pulse).
module serial_nibble_loader
   import serial_nibble_loader_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit PARITY_EN = 1'b1,
   parameter bit ODD       = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             sval,
   input  logic             sdata,
   output logic             busy,
   output logic [WIDTH-1:0] data_out,
   output logic             load,
   output logic             err
);
   state_t state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d, data_q, data_d;
   logic good_q, good_d, clr, inc, tc;
   serial_nibble_loader_bit_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .inc   (inc),
      .tc    (tc)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   always_comb begin
      state_d = state_q;
      if (abort) state_d = IDLE;
      else
         case (state_q)
            IDLE:    state_d = start ? SHIFT : IDLE;
            SHIFT:   state_d = (sval && tc) ? (PARITY_EN ? PARITY : DONE) : SHIFT;
            PARITY:  state_d = sval ? DONE : PARITY;
            default: state_d = IDLE;
         endcase
   end
   // Pulses come from the state plus the registered verdict, so abort cannot cut a DONE pulse short.
   always_comb begin
      busy = state_q != IDLE;
      load = state_q == DONE && good_q;
      err  = state_q == DONE && !good_q;
   end
   // Verdict only matters on the edge into DONE; without parity that edge comes straight from SHIFT.
   always_comb begin
      clr     = abort || (state_q == IDLE && start);
      inc     = !abort && state_q == SHIFT && sval;
      shift_d = (state_q == IDLE && start) ? '0 : inc ? {sdata, shift_q[WIDTH-1:1]} : shift_q;
      good_d  = state_q == PARITY ? !(^shift_q ^ sdata ^ ODD) : state_q == SHIFT ? 1'b1 : good_q;
      data_d  = (state_d == DONE && good_d) ? shift_d : data_q;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         shift_q <= '0;
         data_q  <= '0;
         good_q  <= 1'b0;
      end else begin
         shift_q <= shift_d;
         data_q  <= data_d;
         good_q  <= good_d;
      end
   assign data_out = data_q;
endmodule

// File: tb/tb_serial_nibble_loader.sv
// tb_serial_nibble_loader: table-driven and randomized checks of three builds (even, odd, no parity).
module tb_serial_nibble_loader;
   typedef struct {
      logic [3:0] w;
      bit         p;
      int         stall_at;
      int         stall_len;
      int         abort_at;
      bit         hold;
      bit         exp_load;
      logic [3:0] exp_data;
   } vec_t;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, sval = 1'b0, sdata = 1'b0;
   logic busy, load, err, busy_o, load_o, err_o, busy_n, load_n, err_n;
   logic [3:0] data_out, data_o, data_n;
   logic [3:0] last = '0, last_o = '0, last_n = '0;
   int checks = 0, errors = 0;
   vec_t tbl[11];
   serial_nibble_loader #(.WIDTH(4), .PARITY_EN(1'b1), .ODD(1'b0)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .sval(sval), .sdata(sdata),
      .busy(busy), .data_out(data_out), .load(load), .err(err));
   serial_nibble_loader #(.WIDTH(4), .PARITY_EN(1'b1), .ODD(1'b1)) dut_odd (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .sval(sval), .sdata(sdata),
      .busy(busy_o), .data_out(data_o), .load(load_o), .err(err_o));
   serial_nibble_loader #(.WIDTH(4), .PARITY_EN(1'b0), .ODD(1'b0)) dut_np (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .sval(sval), .sdata(sdata),
      .busy(busy_n), .data_out(data_n), .load(load_n), .err(err_n));
   always #5 clk = ~clk;
   function automatic bit par_ok(input logic [3:0] w, input bit p, input bit odd);
      int ones = int'(p);
      for (int i = 0; i < 4; i++) ones += int'(w[i]);
      return (ones % 2) == int'(odd);
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask
   task automatic step(input bit st, input bit ab, input bit sv, input bit sd);
      start = st; abort = ab; sval = sv; sdata = sd;
      @(posedge clk);
      #1;
   endtask
   task automatic abort_chk();
      chk("abort_busy", busy, 0);
      chk("abort_pulse", {load, err}, 0);
      chk("abort_data", data_out, last);
      chk("abort_odd_pulse", {load_o, err_o}, 0);
      chk("abort_odd_data", data_o, last_o);
      chk("abort_np_data", data_n, last_n);
   endtask
   task automatic run_frame(input vec_t v);
      bit g1 = par_ok(v.w, v.p, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("start_busy", busy, 1);
      for (int i = 0; i < 4; i++) begin
         if (v.abort_at == i) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            abort_chk();
            return;
         end
         if (v.stall_at == i)
            repeat (v.stall_len) begin
               step(v.hold, 1'b0, 1'b0, 1'b1);
               chk("stall_busy", busy, 1);
               chk("stall_pulse", {load, err}, 0);
            end
         step(v.hold, 1'b0, 1'b1, v.w[i]);
         chk("bit_busy", busy, 1);
         chk("bit_pulse", {load, err}, 0);
      end
      chk("np_load", load_n, 1);
      chk("np_err", err_n, 0);
      chk("np_data", data_n, v.w);
      last_n = v.w;
      if (v.abort_at == 4) begin
         step(1'b0, 1'b1, 1'b0, 1'b0);
         abort_chk();
         return;
      end
      if (v.stall_at == 4)
         repeat (v.stall_len) begin
            step(v.hold, 1'b0, 1'b0, 1'b0);
            chk("par_stall_busy", busy, 1);
            chk("par_stall_pulse", {load, err}, 0);
         end
      step(v.hold, v.abort_at == 5, 1'b1, v.p);
      if (v.abort_at == 5) begin
         abort_chk();
         return;
      end
      chk("done_busy", busy, 1);
      chk("done_load", load, v.exp_load);
      chk("done_err", err, !v.exp_load);
      chk("done_data", data_out, v.exp_data);
      last = v.exp_data;
      if (g1) last_o = v.w;
      chk("odd_load", load_o, g1);
      chk("odd_err", err_o, !g1);
      chk("odd_data", data_o, last_o);
      step(v.hold, 1'b0, 1'b0, 1'b0);
      chk("gap_busy", busy, 0);
      chk("gap_pulse", {load, err}, 0);
      chk("gap_data", data_out, last);
   endtask
   initial begin
      vec_t v;
      tbl[0]  = '{4'hB, 1'b1, -1, 0, -1, 1'b0, 1'b1, 4'hB};
      tbl[1]  = '{4'hB, 1'b0, -1, 0, -1, 1'b0, 1'b0, 4'hB};
      tbl[2]  = '{4'h6, 1'b0,  2, 3, -1, 1'b0, 1'b1, 4'h6};
      tbl[3]  = '{4'h5, 1'b0, -1, 0,  2, 1'b0, 1'b0, 4'h6};
      tbl[4]  = '{4'h3, 1'b0, -1, 0, -1, 1'b0, 1'b1, 4'h3};
      tbl[5]  = '{4'hA, 1'b0, -1, 0, -1, 1'b1, 1'b1, 4'hA};
      tbl[6]  = '{4'h5, 1'b0, -1, 0, -1, 1'b1, 1'b1, 4'h5};
      tbl[7]  = '{4'hF, 1'b0, -1, 0,  5, 1'b0, 1'b0, 4'h5};
      tbl[8]  = '{4'h1, 1'b1, -1, 0,  4, 1'b0, 1'b0, 4'h5};
      tbl[9]  = '{4'h8, 1'b1, -1, 0, -1, 1'b0, 1'b1, 4'h8};
      tbl[10] = '{4'h7, 1'b1,  4, 2, -1, 1'b0, 1'b1, 4'h7};
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_pulse", {load, err}, 0);
      chk("rst_data", data_out, 0);
      reset = 1'b0;
      step(1'b0, 1'b0, 1'b1, 1'b1);
      chk("idle_ignores_sval", busy, 0);
      foreach (tbl[i]) run_frame(tbl[i]);
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 2)) begin
            step(1'b0, 1'b0, 1'($urandom), 1'($urandom));
            chk("rand_idle_busy", busy, 0);
         end
         v.w = 4'($urandom_range(0, 15));
         v.p = 1'($urandom_range(0, 1));
         v.stall_at = $urandom_range(0, 6);
         v.stall_len = $urandom_range(1, 3);
         v.abort_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 5) : -1;
         v.hold = 1'b0;
         v.exp_load = par_ok(v.w, v.p, 1'b0);
         v.exp_data = v.exp_load ? v.w : last;
         run_frame(v);
      end
      run_frame('{4'h9, 1'b0, -1, 0, -1, 1'b0, 1'b1, 4'h9});
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, i[0]);
      chk("pre_rst_busy", busy, 1);
      #3 reset = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_data", data_out, 0);
      chk("midrst_pulse", {load, err, load_n, err_n}, 0);
      chk("midrst_odd_data", data_o, 0);
      chk("midrst_np_data", data_n, 0);
      last = '0; last_o = '0; last_n = '0;
      #1 reset = 1'b0;
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("postrst_busy", busy, 0);
      chk("postrst_pulse", {load, err}, 0);
      run_frame('{4'hC, 1'b0, -1, 0, -1, 1'b0, 1'b1, 4'hC});
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
